cmp_search_ctrl: RTL and testbench
==================================

# cmp_search_ctrl

Sequential binary-search engine that drives the probe operand of an external combinational magnitude comparator and consumes its less/equal/greater flags to locate an unknown N-bit target. The comparator compares `probe` against a target held elsewhere. The block narrows a [lo, hi] window one probe per cycle and reports the matching value, the number of probes used, or an error. It sits on the requesting side of the comparator, alongside the comparator in the same datapath.

## Interface
- `N`, default 4: operand width; search space is 0 .. 2^N-1.
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request a new search; sampled only in IDLE.
- `probe`  out  N  value presented to the comparator (comparator computes probe vs target).
- `cmp_less`  in  1  probe < target (combinational response to current `probe`).
- `cmp_equal`  in  1  probe == target.
- `cmp_greater`  in  1  probe > target.
- `busy`  out  1  high while in SEARCH.
- `done`  out  1  one-cycle completion pulse.
- `found`  out  1  search ended on equal; held until next start.
- `error`  out  1  search aborted (flags not one-hot, or window exhausted); held until next start.
- `result`  out  N  matching probe value when `found`, else 0; held until next start.
- `steps`  out  $clog2(N+2)  probes evaluated in the last search; held until next start.

## Operation
- States: IDLE, SEARCH, DONE.
- IDLE: `start`=1 -> SEARCH; lo=0, hi=2^N-1, probe=(lo+hi)>>1 = 2^(N-1)-1; clear found/error/result/steps.
- SEARCH, each cycle, sample flags for the current probe and increment steps:
  - exactly `cmp_equal`: result=probe, found=1 -> DONE.
  - exactly `cmp_less`: if probe==2^N-1 then error=1 -> DONE; else lo=probe+1.
  - exactly `cmp_greater`: if probe==0 then error=1 -> DONE; else hi=probe-1.
  - flags not one-hot (none, or more than one asserted): error=1 -> DONE; lo/hi unchanged.
  - After a lo/hi update: if new lo > new hi then error=1 -> DONE; else probe=(new lo + new hi)>>1.
- Midpoint computed in N+1 bits; no overflow at lo=hi=2^N-1.
- DONE: `done`=1 for exactly this cycle -> IDLE unconditionally.
- `start` ignored in SEARCH and DONE; no queuing.
- `probe` holds its last value in IDLE and DONE.
- With a static target and a correct comparator, every search ends with found=1 within N+1 probes. Error is reachable only through inconsistent flags or a target that changes mid-search.

## Timing
- Reset values: probe=0, busy=0, done=0, found=0, error=0, result=0, steps=0, state IDLE.
- `rst` takes priority over all other inputs in every state. Reset mid-search returns to IDLE next edge with all reset values; no done pulse.
- Start accepted at edge E0. First probe is visible after E0, and its flags are sampled at E1.
- A search using k probes raises `done` in the cycle after edge Ek. `done` is high for one cycle, and `busy` is high for k cycles.
- found/error/result/steps are valid in the same cycle as `done`.
- Comparator path is combinational: flags must settle within the same cycle `probe` changes. No registered flag inputs.
- Back-to-back: `start` is first accepted in the IDLE cycle after DONE, so there is a minimum of one idle cycle between searches.

## Test plan
- N=4, target 11: probes 7 (less), 11 (equal) -> done 2 cycles after start, found=1, result=11, steps=2, error=0.
- N=4, target 15: probes 7, 11, 13, 14, 15 -> found=1, result=15, steps=5 (the N+1 maximum). Target 0: probes 7, 3, 1, 0 -> result=0, steps=4.
- Exhaustive N=4 sweep of targets 0..15 -> found=1 and result==target for all; steps ≤5 for all; busy high exactly `steps` cycles.
- Tie all flags low on first probe -> done after 1 cycle, error=1, found=0, result=0, steps=1. Assert less and greater together -> same outcome.
- Model the comparator as always returning less (target unreachable) -> probes 7, 11, 13, 14, 15 -> error=1 with steps=5; no probe exceeds 15.
- Assert `rst` during the 3rd SEARCH cycle -> next cycle all outputs at reset values, no done pulse. Pulse `start` while busy -> ignored; the in-flight search completes unchanged.

Source files
------------

// File: rtl/cmp_search_ctrl.sv
// Binary-search controller: drives a comparator probe and narrows a [lo, hi]
// window from the returned less/equal/greater flags until the target is found.
module cmp_search_ctrl #(
    parameter  int N  = 4,
    localparam int SW = $clog2(N + 2)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    output logic [N-1:0]  probe_o,
    input  logic          cmp_less_i,
    input  logic          cmp_equal_i,
    input  logic          cmp_greater_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          found_o,
    output logic          error_o,
    output logic [N-1:0]  result_o,
    output logic [SW-1:0] steps_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_DONE
    } state_t;

    localparam logic [N-1:0] MAXV = '1;
    localparam logic [N-1:0] MIDV = MAXV >> 1;

    state_t        state_q, state_d;
    logic [N-1:0]  lo_q, lo_d;
    logic [N-1:0]  hi_q, hi_d;
    logic [N-1:0]  probe_q, probe_d;
    logic          found_q, found_d;
    logic          error_q, error_d;
    logic [N-1:0]  result_q, result_d;
    logic [SW-1:0] steps_q, steps_d;

    logic [N-1:0]  lo_n;
    logic [N-1:0]  hi_n;
    logic          upd;
    logic [N:0]    sum;
    logic [2:0]    flags;

    assign flags = {cmp_less_i, cmp_equal_i, cmp_greater_i};

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        probe_d  = probe_q;
        found_d  = found_q;
        error_d  = error_q;
        result_d = result_q;
        steps_d  = steps_q;
        lo_n     = lo_q;
        hi_n     = hi_q;
        upd      = 1'b0;
        sum      = '0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_SEARCH;
                    lo_d     = '0;
                    hi_d     = MAXV;
                    probe_d  = MIDV;
                    found_d  = 1'b0;
                    error_d  = 1'b0;
                    result_d = '0;
                    steps_d  = '0;
                end
            end

            S_SEARCH: begin
                steps_d = steps_q + SW'(1);
                case (flags)
                    3'b010: begin
                        result_d = probe_q;
                        found_d  = 1'b1;
                        state_d  = S_DONE;
                    end
                    3'b100: begin
                        if (probe_q == MAXV) begin
                            error_d = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            lo_n = probe_q + N'(1);
                            upd  = 1'b1;
                        end
                    end
                    3'b001: begin
                        if (probe_q == '0) begin
                            error_d = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            hi_n = probe_q - N'(1);
                            upd  = 1'b1;
                        end
                    end
                    default: begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end
                endcase

                // Midpoint uses one extra bit so lo=hi=max cannot wrap.
                if (upd) begin
                    lo_d = lo_n;
                    hi_d = hi_n;
                    if (lo_n > hi_n) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        sum     = {1'b0, lo_n} + {1'b0, hi_n};
                        probe_d = sum[N:1];
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            probe_q  <= '0;
            found_q  <= 1'b0;
            error_q  <= 1'b0;
            result_q <= '0;
            steps_q  <= '0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            probe_q  <= probe_d;
            found_q  <= found_d;
            error_q  <= error_d;
            result_q <= result_d;
            steps_q  <= steps_d;
        end
    end

    assign probe_o  = probe_q;
    assign busy_o   = (state_q == S_SEARCH);
    assign done_o   = (state_q == S_DONE);
    assign found_o  = found_q;
    assign error_o  = error_q;
    assign result_o = result_q;
    assign steps_o  = steps_q;

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Directed bench for cmp_search_ctrl with a behavioural comparator
// that can be forced into inconsistent flag patterns.
module tb_cmp_search_ctrl;

    localparam int N  = 4;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N-1:0]  probe;
    logic          less, equal, greater;
    logic          busy, done, found, error;
    logic [N-1:0]  result;
    logic [SW-1:0] steps;

    int tests = 0;
    int fails = 0;

    logic [3:0] tgt  = '0;
    int         mode = 0;

    int          lat, bcnt, dcnt;
    logic [31:0] seq;
    logic [3:0]  maxp;
    logic        done_after, busy_after, found_after;

    always #5 clk = ~clk;

    cmp_search_ctrl #(.N(N)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .probe_o       (probe),
        .cmp_less_i    (less),
        .cmp_equal_i   (equal),
        .cmp_greater_i (greater),
        .busy_o        (busy),
        .done_o        (done),
        .found_o       (found),
        .error_o       (error),
        .result_o      (result),
        .steps_o       (steps)
    );

    // mode 0: honest; 1: no flags; 2: less+greater; 3: always less
    always_comb begin
        less    = 1'b0;
        equal   = 1'b0;
        greater = 1'b0;
        case (mode)
            0: begin
                less    = (probe < tgt);
                equal   = (probe == tgt);
                greater = (probe > tgt);
            end
            1: ;
            2: begin
                less    = 1'b1;
                greater = 1'b1;
            end
            default: less = 1'b1;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [3:0] t, input int md, input int pulse_at);
        tgt  = t;
        mode = md;
        seq  = '0;
        maxp = '0;
        bcnt = 0;
        lat  = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) begin
                bcnt++;
                seq = {seq[27:0], probe};
                if (probe > maxp) maxp = probe;
            end
            start = (lat == pulse_at);
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic step_after();
        @(negedge clk);
        done_after  = done;
        busy_after  = busy;
        found_after = found;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_probe"},  {28'd0, probe},  32'd0);
        check({tag, "_busy"},   {31'd0, busy},   32'd0);
        check({tag, "_done"},   {31'd0, done},   32'd0);
        check({tag, "_found"},  {31'd0, found},  32'd0);
        check({tag, "_error"},  {31'd0, error},  32'd0);
        check({tag, "_result"}, {28'd0, result}, 32'd0);
        check({tag, "_steps"},  {29'd0, steps},  32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;

        run(4'd11, 0, -1);
        check("t11_lat",    lat,              32'd2);
        check("t11_busy",   bcnt,             32'd2);
        check("t11_seq",    seq,              32'h7B);
        check("t11_found",  {31'd0, found},   32'd1);
        check("t11_error",  {31'd0, error},   32'd0);
        check("t11_result", {28'd0, result},  32'd11);
        check("t11_steps",  {29'd0, steps},   32'd2);
        step_after();
        check("t11_done1",  {31'd0, done_after},  32'd0);
        check("t11_idle",   {31'd0, busy_after},  32'd0);
        check("t11_hold",   {31'd0, found_after}, 32'd1);

        run(4'd15, 0, -1);
        check("t15_seq",    seq,             32'h7BDEF);
        check("t15_result", {28'd0, result}, 32'd15);
        check("t15_steps",  {29'd0, steps},  32'd5);
        check("t15_found",  {31'd0, found},  32'd1);

        run(4'd0, 0, -1);
        check("t0_seq",    seq,             32'h7310);
        check("t0_result", {28'd0, result}, 32'd0);
        check("t0_steps",  {29'd0, steps},  32'd4);
        check("t0_found",  {31'd0, found},  32'd1);

        for (int t = 0; t < 16; t++) begin
            run(4'(t), 0, -1);
            check("sw_found",  {31'd0, found},  32'd1);
            check("sw_error",  {31'd0, error},  32'd0);
            check("sw_result", {28'd0, result}, t);
            check("sw_le5",    {31'd0, (steps <= 3'd5)}, 32'd1);
            check("sw_busy",   bcnt, {29'd0, steps});
        end

        run(4'd9, 1, -1);
        check("none_lat",    lat,             32'd1);
        check("none_error",  {31'd0, error},  32'd1);
        check("none_found",  {31'd0, found},  32'd0);
        check("none_result", {28'd0, result}, 32'd0);
        check("none_steps",  {29'd0, steps},  32'd1);

        run(4'd9, 2, -1);
        check("lg_lat",    lat,             32'd1);
        check("lg_error",  {31'd0, error},  32'd1);
        check("lg_found",  {31'd0, found},  32'd0);
        check("lg_result", {28'd0, result}, 32'd0);
        check("lg_steps",  {29'd0, steps},  32'd1);

        run(4'd9, 3, -1);
        check("al_seq",   seq,             32'h7BDEF);
        check("al_error", {31'd0, error},  32'd1);
        check("al_found", {31'd0, found},  32'd0);
        check("al_steps", {29'd0, steps},  32'd5);
        check("al_maxp",  {28'd0, maxp},   32'd15);

        // Reset in the third SEARCH cycle.
        tgt  = 4'd15;
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("mid");
        rst  = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dcnt++;
        end
        check("mid_quiet", dcnt, 32'd0);

        run(4'd15, 0, 2);
        check("pb_seq",    seq,             32'h7BDEF);
        check("pb_lat",    lat,             32'd5);
        check("pb_busy",   bcnt,            32'd5);
        check("pb_steps",  {29'd0, steps},  32'd5);
        check("pb_result", {28'd0, result}, 32'd15);
        check("pb_error",  {31'd0, error},  32'd0);
        step_after();
        check("pb_idle",   {31'd0, busy_after}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
